// File: rtl/write_command_scheduler_if.sv
// Requester/buffer/response bundle for the write command scheduler.
// The master side drives requests and responses; the slave side is the scheduler.
interface write_command_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int LINE_W  = 512
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*LINE_W-1:0] req_data_0;
    logic [NUM_REQ*LINE_W-1:0] req_data_1;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      command_write_valid;
    logic [7:0]                command_tag_out;
    logic [LINE_W-1:0]         write_data_0_out;
    logic [LINE_W-1:0]         write_data_1_out;
    logic [2:0]                grant_id;
    logic                      response_valid;
    logic [7:0]                response_tag;

    modport master (
        output req_valid, req_data_0, req_data_1, response_valid, response_tag,
        input  req_ready, command_write_valid, command_tag_out,
               write_data_0_out, write_data_1_out, grant_id
    );

    modport slave (
        input  req_valid, req_data_0, req_data_1, response_valid, response_tag,
        output req_ready, command_write_valid, command_tag_out,
               write_data_0_out, write_data_1_out, grant_id
    );
endinterface

// File: rtl/write_command_scheduler.sv
// Round-robin write scheduler: grants one requester per cycle, tags the write
// from a free-tag pool and returns tags to the pool on command response.
module write_command_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int LINE_W    = 512,
    parameter int TAG_COUNT = 32
) (
    input  logic                     clock,
    input  logic                     rstn,
    input  logic                     enabled,
    write_command_scheduler_if.slave bus,
    output logic [8:0]               outstanding,
    output logic                     tag_error
);
    logic [TAG_COUNT-1:0] busy;
    logic [TAG_COUNT-1:0] busy_next;
    logic [2:0]           rr_ptr;
    logic [2:0]           grant_idx;
    logic                 grant_found;
    logic                 pool_free;
    logic [7:0]           free_tag;
    logic                 accept;
    logic                 resp_busy;
    logic                 free_ok;
    logic                 bad_free;
    logic [NUM_REQ-1:0]   ready;
    logic [LINE_W-1:0]    sel_data_0;
    logic [LINE_W-1:0]    sel_data_1;

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        pool_free = 1'b0;
        free_tag  = '0;
        // Descending scan so the lowest-index free tag is the last one written.
        for (int t = TAG_COUNT - 1; t >= 0; t--) begin
            if (!busy[t]) begin
                pool_free = 1'b1;
                free_tag  = 8'(t);
            end
        end

        grant_found = 1'b0;
        grant_idx   = '0;
        // Distance k from the rr pointer; smallest distance with a valid request wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_valid[i] && ((int'(rr_ptr) + k) % NUM_REQ) == i) begin
                    grant_found = 1'b1;
                    grant_idx   = 3'(i);
                end
            end
        end

        accept = grant_found && pool_free && enabled && rstn;

        ready      = '0;
        sel_data_0 = '0;
        sel_data_1 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == 3'(i)) begin
                ready[i]   = accept;
                sel_data_0 = bus.req_data_0[i*LINE_W +: LINE_W];
                sel_data_1 = bus.req_data_1[i*LINE_W +: LINE_W];
            end
        end

        // Out-of-range tags never match a pool entry, so they read as not busy.
        resp_busy = 1'b0;
        for (int t = 0; t < TAG_COUNT; t++) begin
            if (bus.response_tag == 8'(t)) resp_busy = busy[t];
        end
        free_ok  = bus.response_valid && resp_busy;
        bad_free = bus.response_valid && !resp_busy;

        busy_next = busy;
        for (int t = 0; t < TAG_COUNT; t++) begin
            if (free_ok && bus.response_tag == 8'(t)) busy_next[t] = 1'b0;
            if (accept && free_tag == 8'(t))          busy_next[t] = 1'b1;
        end
    end

    assign bus.req_ready = ready;

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            busy                    <= '0;
            rr_ptr                  <= '0;
            bus.command_write_valid <= 1'b0;
            bus.command_tag_out     <= '0;
            bus.write_data_0_out    <= '0;
            bus.write_data_1_out    <= '0;
            bus.grant_id            <= '0;
            outstanding             <= '0;
            tag_error               <= 1'b0;
        end else begin
            busy                    <= busy_next;
            bus.command_write_valid <= accept;
            outstanding             <= outstanding + 9'(accept) - 9'(free_ok);
            if (accept) begin
                rr_ptr               <= (grant_idx == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
                bus.command_tag_out  <= free_tag;
                bus.write_data_0_out <= sel_data_0;
                bus.write_data_1_out <= sel_data_1;
                bus.grant_id         <= grant_idx;
            end
            if (bad_free) tag_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_write_command_scheduler.sv
// Directed bench for write_command_scheduler: arbitration order, tag pool
// allocate/free, pool-full stall, bad frees, enable gating and async reset.
module tb_write_command_scheduler;
    localparam int NUM_REQ   = 4;
    localparam int LINE_W    = 512;
    localparam int TAG_COUNT = 32;

    logic       clock = 1'b0;
    logic       rstn;
    logic       enabled;
    logic [8:0] outstanding;
    logic       tag_error;
    int         total = 0;
    int         bad   = 0;

    write_command_scheduler_if #(.NUM_REQ(NUM_REQ), .LINE_W(LINE_W)) bus ();

    write_command_scheduler #(
        .NUM_REQ  (NUM_REQ),
        .LINE_W   (LINE_W),
        .TAG_COUNT(TAG_COUNT)
    ) dut (
        .clock      (clock),
        .rstn       (rstn),
        .enabled    (enabled),
        .bus        (bus),
        .outstanding(outstanding),
        .tag_error  (tag_error)
    );

    always #5 clock = ~clock;

    function automatic logic [LINE_W-1:0] pat(input int idx, input int half);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(half * 256 + idx);
        return {(LINE_W / 32){w}};
    endfunction

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Registered strobe outputs, sampled 1 time unit after the active edge.
    task automatic chk_cmd(input string tag, input logic cwv, input int ctag, input int gid);
        chk({tag, ".cwv"}, LINE_W'(bus.command_write_valid), LINE_W'(cwv));
        chk({tag, ".tag"}, LINE_W'(bus.command_tag_out), LINE_W'(ctag));
        chk({tag, ".gid"}, LINE_W'(bus.grant_id), LINE_W'(gid));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rstn               = 1'b0;
        bus.req_valid      = '0;
        bus.response_valid = 1'b0;
        bus.response_tag   = '0;
        enabled            = 1'b1;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        rstn               = 1'b1;
        enabled            = 1'b1;
        bus.req_valid      = 4'b1111;
        bus.response_valid = 1'b0;
        bus.response_tag   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_data_0[i*LINE_W +: LINE_W] = pat(i, 0);
            bus.req_data_1[i*LINE_W +: LINE_W] = pat(i, 1);
        end

        // Reset state, with requests pending and enabled high.
        #2 rstn = 1'b0;
        #1;
        chk("rst.ready", LINE_W'(bus.req_ready), '0);
        chk_cmd("rst", 1'b0, 0, 0);
        chk("rst.d0", bus.write_data_0_out, '0);
        chk("rst.d1", bus.write_data_1_out, '0);
        chk("rst.outstanding", LINE_W'(outstanding), '0);
        chk("rst.tag_error", LINE_W'(tag_error), '0);

        // Single request from requester 0.
        do_reset();
        bus.req_valid = 4'b0001;
        #1 chk("single.ready", LINE_W'(bus.req_ready), LINE_W'(4'b0001));
        tick();
        bus.req_valid = '0;
        chk_cmd("single", 1'b1, 0, 0);
        chk("single.d0", bus.write_data_0_out, pat(0, 0));
        chk("single.d1", bus.write_data_1_out, pat(0, 1));
        chk("single.outstanding", LINE_W'(outstanding), LINE_W'(1));
        tick();
        chk("idle.cwv", LINE_W'(bus.command_write_valid), '0);
        chk("idle.d0_hold", bus.write_data_0_out, pat(0, 0));

        // All four requesting: round-robin order, tags in order, fill the pool.
        do_reset();
        bus.req_valid = 4'b1111;
        for (int k = 0; k < TAG_COUNT; k++) begin
            #1 chk($sformatf("rr%0d.ready", k), LINE_W'(bus.req_ready), LINE_W'(4'b0001 << (k % 4)));
            tick();
            chk_cmd($sformatf("rr%0d", k), 1'b1, k, k % 4);
            chk($sformatf("rr%0d.d1", k), bus.write_data_1_out, pat(k % 4, 1));
            if (k == 7) chk("rr8.outstanding", LINE_W'(outstanding), LINE_W'(8));
        end
        chk("full.outstanding", LINE_W'(outstanding), LINE_W'(32));
        chk("full.ready", LINE_W'(bus.req_ready), '0);
        tick();
        chk("full.cwv", LINE_W'(bus.command_write_valid), '0);

        // Free tag 5: no same-cycle bypass, then reused next cycle.
        bus.response_valid = 1'b1;
        bus.response_tag   = 8'd5;
        #1 chk("free5.no_bypass", LINE_W'(bus.req_ready), '0);
        tick();
        bus.response_valid = 1'b0;
        chk("free5.outstanding", LINE_W'(outstanding), LINE_W'(31));
        #1 chk("free5.ready", LINE_W'(bus.req_ready), LINE_W'(4'b0001));
        tick();
        chk_cmd("reuse5", 1'b1, 5, 0);
        chk("reuse5.outstanding", LINE_W'(outstanding), LINE_W'(32));

        // Free 7, then grant tag 7 while freeing 9 in the same cycle.
        bus.req_valid      = '0;
        bus.response_valid = 1'b1;
        bus.response_tag   = 8'd7;
        tick();
        bus.req_valid    = 4'b0001;
        bus.response_tag = 8'd9;
        #1 chk("simul.ready", LINE_W'(bus.req_ready), LINE_W'(4'b0001));
        tick();
        bus.req_valid      = '0;
        bus.response_valid = 1'b0;
        chk_cmd("simul", 1'b1, 7, 0);
        chk("simul.outstanding", LINE_W'(outstanding), LINE_W'(31));
        chk("simul.tag_error", LINE_W'(tag_error), '0);

        // Bad frees: never-allocated tag, then out-of-range tag.
        do_reset();
        bus.response_valid = 1'b1;
        bus.response_tag   = 8'd3;
        tick();
        bus.response_valid = 1'b0;
        chk("bad3.tag_error", LINE_W'(tag_error), LINE_W'(1));
        chk("bad3.outstanding", LINE_W'(outstanding), '0);
        tick();
        chk("bad3.sticky", LINE_W'(tag_error), LINE_W'(1));
        do_reset();
        chk("bad40.cleared", LINE_W'(tag_error), '0);
        bus.response_valid = 1'b1;
        bus.response_tag   = 8'd40;
        tick();
        bus.response_valid = 1'b0;
        chk("bad40.tag_error", LINE_W'(tag_error), LINE_W'(1));
        chk("bad40.outstanding", LINE_W'(outstanding), '0);

        // Enable gating; in-flight strobe survives enable dropping.
        do_reset();
        bus.req_valid = 4'b0001;
        tick();
        enabled       = 1'b0;
        bus.req_valid = 4'b1111;
        chk("en.inflight", LINE_W'(bus.command_write_valid), LINE_W'(1));
        #1 chk("en.off_ready", LINE_W'(bus.req_ready), '0);
        tick();
        chk("en.off_cwv", LINE_W'(bus.command_write_valid), '0);
        chk("en.off_outstanding", LINE_W'(outstanding), LINE_W'(1));
        enabled = 1'b1;
        #1 chk("en.on_ready", LINE_W'(bus.req_ready), LINE_W'(4'b0010));
        tick();
        chk_cmd("en.on", 1'b1, 1, 1);
        chk("en.on_outstanding", LINE_W'(outstanding), LINE_W'(2));

        // Async reset right after an accept kills the strobe and the pool.
        do_reset();
        bus.req_valid = 4'b0010;
        tick();
        chk_cmd("pre_rst", 1'b1, 0, 1);
        rstn = 1'b0;
        #1;
        chk("midrst.cwv", LINE_W'(bus.command_write_valid), '0);
        chk("midrst.outstanding", LINE_W'(outstanding), '0);
        chk("midrst.ready", LINE_W'(bus.req_ready), '0);
        tick();
        rstn          = 1'b1;
        bus.req_valid = 4'b1111;
        #1 chk("postrst.ready", LINE_W'(bus.req_ready), LINE_W'(4'b0001));
        tick();
        chk_cmd("postrst", 1'b1, 0, 0);
        chk("postrst.outstanding", LINE_W'(outstanding), LINE_W'(1));

        bus.req_valid = '0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/write_command_scheduler.md
Name: write_command_scheduler

Overview:
- Shares the AFU write-data buffer path between NUM_REQ requesters (engines producing cache-line writes).
- Round-robin arbitration; allocates a free 8-bit command tag from a tag pool and drives the write-buffer write port (valid, tag, two half-line data words).
- Returns tags to the pool on command response.
- Sits between the compute engines and the write data control block, which serves PSL buffer reads by tag.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LINE_W, 512, width of one half cache line data word.
- TAG_COUNT, 32, number of tags in the pool, tags 0..TAG_COUNT-1 (power of 2, ≤256).

Ports:
- clock  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- enabled  in  1  grants allowed only when high.
- req_valid  in  NUM_REQ  request valid per requester.
- req_data_0  in  NUM_REQ*LINE_W  first half line; requester i at slice [i*LINE_W +: LINE_W].
- req_data_1  in  NUM_REQ*LINE_W  second half line, same slicing.
- req_ready  out  NUM_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i].
- command_write_valid  out  1  write-buffer write strobe.
- command_tag_out  out  8  tag of write (upper bits zero beyond TAG_COUNT).
- write_data_0_out  out  LINE_W  first half line to buffer.
- write_data_1_out  out  LINE_W  second half line to buffer.
- grant_id  out  3  requester index associated with command_write_valid.
- response_valid  in  1  command response received; frees response_tag.
- response_tag  in  8  tag being freed.
- outstanding  out  9  count of allocated tags.
- tag_error  out  1  sticky: free of unallocated or out-of-range tag.

Behaviour:
- Reset (rstn low, async): all tags free; rr pointer = 0; command_write_valid=0, command_tag_out=0, write_data_*_out=0, grant_id=0, outstanding=0, tag_error=0. req_ready is combinational and 0 while in reset.
- Grant (combinational): req_ready[i]=1 for at most one i when all of the following hold:
  - enabled=1;
  - the pool has a free tag;
  - i is the first requester with req_valid set, searching cyclically from rr pointer.
- Tag choice: lowest-index free tag.
- Accept cycle N:
  - tag marked busy at edge N;
  - rr pointer ← granted index + 1 (mod NUM_REQ).
- Cycle N+1 (registered outputs):
  - command_write_valid=1;
  - command_tag_out=chosen tag;
  - write_data_0_out/write_data_1_out=granted requester data;
  - grant_id=index.
- Latency: one cycle, accept to strobe. Throughput: one write per cycle. command_write_valid is low on cycles with no accept; data outputs hold their last values.
- Free: on response_valid with tag busy and < TAG_COUNT, tag freed at that edge and available for grant the next cycle; no same-cycle bypass.
- Bad free: on response_valid with tag not busy or ≥ TAG_COUNT, tag_error ← 1 (sticky until reset); pool unchanged.
- Simultaneous allocate and free (different tags by construction): outstanding unchanged.
- outstanding: allocated-tag count, updated each edge as +accept −valid_free.
- Pool full (outstanding=TAG_COUNT): req_ready all 0; requests held and not dropped.
- enabled low: no new grants; in-flight strobe from the prior accept still issues; frees still processed.
- Reset mid-operation: all state cleared immediately, including an in-flight strobe; tags outstanding at PSL are forgotten.
- Requester may drop req_valid before grant without penalty.

Test Plan:
- Reset, then req_valid=4'b0001, data_0=A, data_1=B → req_ready=0001 same cycle; next cycle command_write_valid=1, tag=0, data A/B, grant_id=0, outstanding=1.
- req_valid=4'b1111 held 8 cycles, no frees → grant order 0,1,2,3,0,1,2,3; tags 0..7; outstanding=8.
- Fill 32 tags with no responses → req_ready=0 on cycle 33. response_tag=5 → grant the next cycle, reusing tag 5; outstanding stays 32.
- response_valid with tag 3 never allocated → tag_error=1, outstanding unchanged. Also response_tag=40 with TAG_COUNT=32 → tag_error=1.
- enabled=0 with req_valid=1111 → no req_ready. On enabled=1, grant goes to the rr pointer's requester.
- Assert rstn=0 in the cycle after an accept → command_write_valid=0 immediately, outstanding=0. After release, first grant uses tag 0, requester 0.
